// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I core.
// Enum encodings of the mux selects match the datapath mux input ordering.
package riscv_pkg;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_ITYPE = 2'b11
   } aluop_t;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWR,
      S_WB_MEM,
      S_EXEC_R,
      S_EXEC_I,
      S_WB_ALU,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_LUI,
      S_TRAP
   } ctrl_state_t;

   typedef enum logic {ADDR_PC, ADDR_ALUOUT} addrsel_t;
   typedef enum logic {PC_ALU, PC_ALUOUT} pcsel_t;
   typedef enum logic [1:0] {A_RS1, A_PC, A_OLDPC, A_ZERO} srca_t;
   typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} srcb_t;
   typedef enum logic [1:0] {WB_ALUOUT, WB_MEM, WB_PC} wbsel_t;

   localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
   localparam logic [6:0] OPCODE_OP       = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
   localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;

endpackage

// File: rtl/opcode_decoder.sv
// Maps the IR opcode to the state entered after DECODE.
// Anything not recognised lands in TRAP; FENCE goes straight back to FETCH.
module opcode_decoder
   import riscv_pkg::*;
(
   input  logic [6:0]  opcode,
   output ctrl_state_t next_state
);

   always_comb begin
      next_state = S_TRAP;
      case (opcode)
         OPCODE_LOAD,
         OPCODE_STORE:    next_state = S_MEMADR;
         OPCODE_OP:       next_state = S_EXEC_R;
         OPCODE_OP_IMM:   next_state = S_EXEC_I;
         OPCODE_BRANCH:   next_state = S_BRANCH;
         OPCODE_JAL:      next_state = S_JAL;
         OPCODE_JALR:     next_state = S_JALR;
         OPCODE_LUI:      next_state = S_LUI;
         OPCODE_AUIPC:    next_state = S_WB_ALU;
         OPCODE_MISC_MEM: next_state = S_FETCH;
         default:         next_state = S_TRAP;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences the shared datapath
// and drives ALU op, mux selects and write strobes.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | read instr at PC, on ready latch IR/OLDPC and PC<-PC+4
// DECODE   | ALUOUT<-OLDPC+imm, dispatch on opcode (FENCE retires here)
// MEMADR   | ALUOUT<-rs1+imm for load/store
// MEMRD    | data read at ALUOUT, wait for ready
// MEMWR    | data write at ALUOUT, retire on ready
// WB_MEM   | write load data to rd
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm
// LUI      | 0+imm
// WB_ALU   | write ALUOUT to rd
// BRANCH   | compare rs1/rs2, PC<-ALUOUT if taken
// JAL      | PC<-ALUOUT, rd<-PC
// JALR     | PC<-rs1+imm, rd<-PC
// TRAP     | illegal opcode, halted until reset
module multicycle_control
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output logic       mem_req,
   output logic       mem_we,
   output addrsel_t   addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output pcsel_t     pc_sel,
   output srca_t      alu_src_a,
   output srcb_t      alu_src_b,
   output aluop_t     aluop,
   output logic       reg_we,
   output wbsel_t     wb_sel,
   output logic       retire,
   output logic       halted
);

   ctrl_state_t state;
   ctrl_state_t decode_next;

   opcode_decoder u_opcode_decoder (
      .opcode     (opcode),
      .next_state (decode_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  if (mem_ready) state <= S_DECODE;
            S_DECODE: state <= decode_next;
            S_EXEC_R,
            S_EXEC_I,
            S_LUI:    state <= S_WB_ALU;
            // only loads and stores reach MEMADR, so non-store means load
            S_MEMADR: state <= (opcode == OPCODE_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state <= S_WB_MEM;
            S_MEMWR:  if (mem_ready) state <= S_FETCH;
            S_WB_ALU,
            S_WB_MEM,
            S_BRANCH,
            S_JAL,
            S_JALR:   state <= S_FETCH;
            S_TRAP:   state <= S_TRAP;
            default:  state <= S_TRAP;
         endcase
      end
   end

   // Outputs decode from state; only memory-completion strobes and the
   // branch PC write look at inputs. Reset masks every strobe immediately.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = ADDR_PC;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_ALU;
      alu_src_a = A_RS1;
      alu_src_b = B_RS2;
      aluop     = ALUOP_ADD;
      reg_we    = 1'b0;
      wb_sel    = WB_ALUOUT;
      retire    = 1'b0;
      halted    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_a = A_PC;
            alu_src_b = B_FOUR;
            ir_we     = mem_ready;
            pc_we     = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = A_OLDPC;
            alu_src_b = B_IMM;
            retire    = (opcode == OPCODE_MISC_MEM);
         end
         S_EXEC_R: aluop = ALUOP_RTYPE;
         S_EXEC_I: begin
            alu_src_b = B_IMM;
            aluop     = ALUOP_ITYPE;
         end
         S_LUI: begin
            alu_src_a = A_ZERO;
            alu_src_b = B_IMM;
         end
         S_WB_ALU: begin
            reg_we = 1'b1;
            retire = 1'b1;
         end
         S_MEMADR: alu_src_b = B_IMM;
         S_MEMRD: begin
            mem_req  = 1'b1;
            addr_sel = ADDR_ALUOUT;
         end
         S_WB_MEM: begin
            reg_we = 1'b1;
            wb_sel = WB_MEM;
            retire = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_sel = ADDR_ALUOUT;
            retire   = mem_ready;
         end
         S_BRANCH: begin
            aluop  = ALUOP_SUB;
            pc_sel = PC_ALUOUT;
            pc_we  = branch_taken;
            retire = 1'b1;
         end
         S_JAL: begin
            pc_sel = PC_ALUOUT;
            pc_we  = 1'b1;
            reg_we = 1'b1;
            wb_sel = WB_PC;
            retire = 1'b1;
         end
         S_JALR: begin
            alu_src_b = B_IMM;
            pc_we     = 1'b1;
            reg_we    = 1'b1;
            wb_sel    = WB_PC;
            retire    = 1'b1;
         end
         S_TRAP:  halted = 1'b1;
         default: halted = 1'b0;
      endcase
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         reg_we  = 1'b0;
         retire  = 1'b0;
         halted  = 1'b0;
      end
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM of the multicycle RV32I core. Sequences the shared datapath (ALU, register file, PC, IR, unified memory port) through fetch/decode/execute/memory/writeback states, driving `aluop` into `alu_control` and all mux selects and write strobes. Branch resolution stays in the branch unit; this block only consumes its `branch_taken` verdict.

## Interface
- No parameters.
- `clk` in 1: core clock
- `rst` in 1: synchronous, active-high reset
- `opcode` in 7: IR[6:0], valid from DECODE onward
- `mem_ready` in 1: memory completes request this cycle
- `branch_taken` in 1: branch unit verdict from current ALU flags
- `mem_req` out 1: memory request, held until `mem_ready`
- `mem_we` out 1: store request, valid with `mem_req`
- `addr_sel` out addrsel_t: ADDR_PC / ADDR_ALUOUT
- `ir_we` out 1: latch IR and OLDPC
- `pc_we` out 1: PC write
- `pc_sel` out pcsel_t: PC_ALU (live result) / PC_ALUOUT (registered)
- `alu_src_a` out srca_t: A_RS1 / A_PC / A_OLDPC / A_ZERO
- `alu_src_b` out srcb_t: B_RS2 / B_IMM / B_FOUR
- `aluop` out aluop_t: ADD 00, SUB 01, RTYPE 10, ITYPE 11
- `reg_we` out 1: register-file write
- `wb_sel` out wbsel_t: WB_ALUOUT / WB_MEM / WB_PC
- `retire` out 1: one-cycle pulse on final cycle of each instruction
- `halted` out 1: sticky, in TRAP

## Operation
- Moore FSM. Outputs decode from state, except FETCH/MEM strobes, which qualify with `mem_ready`. Unlisted outputs are 0 / first enum value.
- FETCH: `mem_req`, ADDR_PC, A_PC, B_FOUR, ADD, PC_ALU. When `mem_ready` is high: `ir_we`, `pc_we` (PC←PC+4), then DECODE.
- DECODE: A_OLDPC, B_IMM, ADD (ALUOUT←branch/JAL/AUIPC target). Next state by opcode: LOAD/STORE→MEMADR, OP→EXEC_R, OP-IMM→EXEC_I, BRANCH→BRANCH, JAL→JAL, JALR→JALR, LUI→LUI, AUIPC→WB_ALU, MISC-MEM→FETCH (retire, FENCE as NOP), others→TRAP.
- EXEC_R: A_RS1, B_RS2, RTYPE→WB_ALU. EXEC_I: A_RS1, B_IMM, ITYPE→WB_ALU. LUI: A_ZERO, B_IMM, ADD→WB_ALU.
- WB_ALU: `reg_we`, WB_ALUOUT, retire→FETCH.
- MEMADR: A_RS1, B_IMM, ADD; LOAD→MEMRD, STORE→MEMWR.
- MEMRD: `mem_req`, ADDR_ALUOUT; when `mem_ready` is high →WB_MEM. WB_MEM: `reg_we`, WB_MEM, retire→FETCH.
- MEMWR: `mem_req`, `mem_we`, ADDR_ALUOUT; when `mem_ready` is high: retire→FETCH.
- BRANCH: A_RS1, B_RS2, SUB, PC_ALUOUT, `pc_we`=`branch_taken`, retire→FETCH.
- JAL: PC_ALUOUT, `pc_we`, `reg_we`, WB_PC (PC already +4), retire→FETCH.
- JALR: A_RS1, B_IMM, ADD, PC_ALU (datapath clears bit 0), `pc_we`, `reg_we`, WB_PC, retire→FETCH.
- TRAP: all strobes 0, `halted`=1, self-loop until `rst`.

## Timing
- Reset: state←FETCH. While `rst` is high, `mem_req`, `mem_we`, `ir_we`, `pc_we`, `reg_we`, and `retire` are forced to 0, and `halted`=0. Reset during a pending memory wait abandons the request; no strobe fires.
- Handshake: `mem_req`, `mem_we`, and `addr_sel` stay stable from assertion until the cycle `mem_ready` is sampled high (inclusive). Zero-wait is allowed: ready in the first request cycle. `mem_ready` is ignored when `mem_req` is 0.
- Cycles with zero memory wait: R/I/LUI 4, load 5, store 4, branch 3, JAL/JALR 3, AUIPC 3, FENCE 2. Each memory wait cycle adds 1.
- In the JAL/JALR cycle, `reg_we` and `pc_we` fire on the same edge; the register file captures pre-update PC (=OLDPC+4).
- `branch_taken` is sampled only in BRANCH.

## Structure
- Shared `riscv_pkg`: aluop_t (existing), ctrl_state_t, addrsel_t, pcsel_t, srca_t, srcb_t, wbsel_t, OPCODE_* constants (LOAD 0000011, STORE 0100011, OP 0110011, OP_IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, MISC_MEM 0001111).
- One combinational sub-module, `opcode_decoder`: opcode→next-from-DECODE state. The FSM register and output decode live in `multicycle_control`.

## Test plan
- `add` (opcode 0110011), `mem_ready` tied 1 → FETCH, DECODE, EXEC_R (aluop=10), WB_ALU (`reg_we`=1, `retire`=1). Next FETCH on cycle 5.
- `lw` with 3 wait cycles on data access → `mem_req`=1 and ADDR_ALUOUT held 4 cycles. WB_MEM 1 cycle after ready; 8 cycles total.
- `beq` with `branch_taken`=0 then 1 → aluop=01 in BRANCH; `pc_we` is 0 then 1 with PC_ALUOUT; 3 cycles each.
- `jalr` → aluop=00, A_RS1/B_IMM; `pc_we`, `reg_we`, and WB_PC all high in one cycle. `retire` pulses once.
- Opcode 1110011 → TRAP. `halted`=1, strobes 0 for 20 cycles. `rst`=1 for one cycle, then FETCH with `mem_req`=1, `halted`=0.
- `rst` asserted mid-MEMWR wait → no `mem_we`/`retire` pulse. After reset, FETCH with ADDR_PC.
